memory_access_arbiter: RTL and testbench
========================================

// Module: memory_access_arbiter
// PURPOSE
//  Sequences and shares the 64x8 single-port memory between one write requester and one read requester.
//  Drives the select, address and data inputs of the memory interface mux; sel=0 is a write (we=1), sel=1 is a read (we=0).
//  Req/gnt handshake on both sides, round-robin arbitration on contention, fixed read latency.
//  Sits between the datapath requesters and memory_interface/memory.
// PARAMETERS
//  ADDR_W  6  address width (memory depth 2**ADDR_W)
//  DATA_W  8  data width
//  RD_LAT  1  memory read latency in cycles, legal 1..3
//  FAIR    1  1 = round-robin on contention; 0 = write always wins
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  wr_req     in   1       write request; addr/data held stable until wr_gnt
//  wr_addr    in   ADDR_W  write address
//  wr_data    in   DATA_W  write data
//  wr_gnt     out  1       1-cycle pulse: write request accepted, operands latched
//  wr_done    out  1       1-cycle pulse: write committed to memory
//  rd_req     in   1       read request; addr held stable until rd_gnt
//  rd_addr    in   ADDR_W  read address
//  rd_gnt     out  1       1-cycle pulse: read request accepted
//  rd_valid   out  1       1-cycle pulse: rd_data valid
//  rd_data    out  DATA_W  read result, held until next rd_valid
//  mem_sel    out  1       to interface sel: 0 = write port (addr_0), 1 = read port (addr_1)
//  mem_addr_0 out  ADDR_W  latched write address
//  mem_addr_1 out  ADDR_W  latched read address
//  mem_data   out  DATA_W  latched write data
//  mem_q      in   DATA_W  memory read data
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; mem_sel=1; wr_gnt, wr_done, rd_gnt, rd_valid, busy all 0.
//  Reset: mem_addr_0, mem_addr_1, mem_data, rd_data all 0; last_served=READ; latency counter 0.
//  Reset mid-operation aborts the transaction: no wr_done/rd_valid is issued for it.
//  mem_sel is 0 ONLY in state WRITE; every other state drives 1, so no spurious write can occur.
//  States: IDLE, WRITE, READ.
//  IDLE, no req: stay.
//  IDLE, wr_req only: latch wr_addr/wr_data, wr_gnt=1 same cycle, next state WRITE.
//  IDLE, rd_req only: latch rd_addr, rd_gnt=1 same cycle, counter=RD_LAT, next state READ.
//  IDLE, both requests: FAIR=1 grants the side opposite last_served; FAIR=0 grants write.
//  WRITE (1 cycle): mem_sel=0; wr_done=1 in this cycle; last_served=WRITE; next state IDLE.
//  READ: mem_sel=1, mem_addr_1 stable, counter decrements each cycle.
//  READ, counter reaches 1: next edge captures mem_q into rd_data; rd_valid=1 that following cycle (in IDLE); last_served=READ.
//  No grant is issued in WRITE or READ; requests wait, no overlap.
//  Latency from grant cycle: write done +1 cycle; read valid +RD_LAT+1 cycles.
//  Throughput: one write per 2 cycles, one read per RD_LAT+1 cycles.
//  A new grant may coincide with the cycle rd_valid is asserted.
//  Requests deasserted before their grant are dropped silently. wr_gnt and rd_gnt are never both 1.
//  Address/data widths pass through unchanged; no arithmetic except the 2-bit latency down-counter.
// TESTING
//  T1 reset: hold rst 2 cycles mid-READ -> all outputs at reset values, no rd_valid afterward, mem_sel=1.
//  T2 write: wr_req, addr=6'h2A, data=8'h5C -> wr_gnt at t0; mem_sel=0, addr_0=2A, data=5C at t1; wr_done at t1.
//  T3 read-back: after T2, rd_req addr=6'h2A with RD_LAT=1 -> rd_gnt at t0; rd_valid at t2 with rd_data=8'h5C.
//  T4 contention: both req held with FAIR=1 -> grants alternate W,R,W,R...; with FAIR=0 -> write only until wr_req drops.
//  T5 latency: RD_LAT=3 -> rd_valid exactly 4 cycles after rd_gnt; busy high for 3 cycles.
//  T6 boundaries: addr 6'h00 and 6'h3F, data 8'hFF/8'h00 -> correct read-back; mem_sel never 0 outside WRITE (assertion).

Source files
------------

// File: rtl/memory_access_arbiter.sv
// Shares one single-port memory between a write requester and a read requester.
// Grants are combinational in IDLE; operands are latched on the grant edge.
module memory_access_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr_0,
  output logic [ADDR_W-1:0] mem_addr_1,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req and its operands stable until it sees a
  // one-cycle gnt; the operands are latched on that edge and req may drop.
  // Completion is signalled by a one-cycle wr_done / rd_valid pulse.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  localparam logic LS_WRITE = 1'b0;
  localparam logic LS_READ  = 1'b1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] lat_cnt;
  logic       last_served;
  logic       grant_wr;
  logic       grant_rd;

  // Arbitration: only IDLE grants; on contention FAIR alternates sides.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (!rst && state == IDLE) begin
      if (wr_req && rd_req) begin
        if (FAIR == 0 || last_served == LS_READ) grant_wr = 1'b1;
        else                                     grant_rd = 1'b1;
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end else if (rd_req) begin
        grant_rd = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_wr)      state_nxt = WRITE;
        else if (grant_rd) state_nxt = READ;
      end
      WRITE:   state_nxt = IDLE;
      READ:    if (lat_cnt == 2'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= 2'd0;
      last_served <= LS_READ;
      mem_addr_0  <= '0;
      mem_addr_1  <= '0;
      mem_data    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      if (grant_wr) begin
        mem_addr_0 <= wr_addr;
        mem_data   <= wr_data;
      end
      if (grant_rd) begin
        mem_addr_1 <= rd_addr;
        lat_cnt    <= 2'(RD_LAT);
      end
      if (state == WRITE) last_served <= LS_WRITE;
      if (state == READ) begin
        lat_cnt <= lat_cnt - 2'd1;
        // Last latency cycle: mem_q is valid for the address held on port 1.
        if (lat_cnt == 2'd1) begin
          rd_data     <= mem_q;
          rd_valid    <= 1'b1;
          last_served <= LS_READ;
        end
      end
    end
  end

  // mem_sel is forced high in reset so a stale WRITE state can never write.
  assign mem_sel   = rst || (state != WRITE);
  assign wr_done   = !rst && (state == WRITE);
  assign busy      = !rst && (state != IDLE);
  assign wr_gnt    = grant_wr;
  assign rd_gnt    = grant_rd;
  assign dbg_state = state;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench: instance a (RD_LAT=1, FAIR=1) and instance b (RD_LAT=3, FAIR=0),
// each attached to a small combinational-read memory behind a sel mux.
module tb_memory_access_arbiter;

  logic clk;
  logic rst;

  logic       a_wr_req, a_wr_gnt, a_wr_done, a_rd_req, a_rd_gnt, a_rd_valid;
  logic       a_mem_sel, a_busy;
  logic [5:0] a_wr_addr, a_rd_addr, a_mem_addr_0, a_mem_addr_1, a_mem_idx;
  logic [7:0] a_wr_data, a_rd_data, a_mem_data, a_mem_q;
  logic [1:0] a_dbg_state;

  logic       b_wr_req, b_wr_gnt, b_wr_done, b_rd_req, b_rd_gnt, b_rd_valid;
  logic       b_mem_sel, b_busy;
  logic [5:0] b_wr_addr, b_rd_addr, b_mem_addr_0, b_mem_addr_1, b_mem_idx;
  logic [7:0] b_wr_data, b_rd_data, b_mem_data, b_mem_q;
  logic [1:0] b_dbg_state;

  logic [7:0] mem_a [0:63];
  logic [7:0] mem_b [0:63];

  int n_assert = 0;
  int n_fail   = 0;

  memory_access_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .FAIR(1)) u_a (
    .clk(clk), .rst(rst),
    .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_gnt(a_wr_gnt), .wr_done(a_wr_done),
    .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_gnt(a_rd_gnt),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .mem_sel(a_mem_sel), .mem_addr_0(a_mem_addr_0), .mem_addr_1(a_mem_addr_1),
    .mem_data(a_mem_data), .mem_q(a_mem_q), .busy(a_busy), .dbg_state(a_dbg_state)
  );

  memory_access_arbiter #(.ADDR_W(6), .DATA_W(8), .RD_LAT(3), .FAIR(0)) u_b (
    .clk(clk), .rst(rst),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_gnt(b_wr_gnt), .wr_done(b_wr_done),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .mem_sel(b_mem_sel), .mem_addr_0(b_mem_addr_0), .mem_addr_1(b_mem_addr_1),
    .mem_data(b_mem_data), .mem_q(b_mem_q), .busy(b_busy), .dbg_state(b_dbg_state)
  );

  // Clock / memory models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a_mem_idx = a_mem_sel ? a_mem_addr_1 : a_mem_addr_0;
  assign b_mem_idx = b_mem_sel ? b_mem_addr_1 : b_mem_addr_0;
  assign a_mem_q   = mem_a[a_mem_idx];
  assign b_mem_q   = mem_b[b_mem_idx];

  always @(posedge clk) begin
    if (a_mem_sel === 1'b0) mem_a[a_mem_idx] <= a_mem_data;
    if (b_mem_sel === 1'b0) mem_b[b_mem_idx] <= b_mem_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Invariants checked every cycle on both instances.
  always @(negedge clk) begin
    #2;
    check("a_sel0_only_in_write", (a_mem_sel === 1'b0) ? a_wr_done : 1'b1, 1);
    check("b_sel0_only_in_write", (b_mem_sel === 1'b0) ? b_wr_done : 1'b1, 1);
    check("a_gnt_exclusive", a_wr_gnt & a_rd_gnt, 0);
    check("b_gnt_exclusive", b_wr_gnt & b_rd_gnt, 0);
  end

  // Driver tasks for instance a; each starts with a in IDLE.
  task automatic do_write_a(input logic [5:0] addr, input logic [7:0] data);
    @(negedge clk);
    a_wr_req = 1'b1; a_wr_addr = addr; a_wr_data = data;
    #1;
    check("wa_gnt", a_wr_gnt, 1);
    @(negedge clk);
    a_wr_req = 1'b0;
    #1;
    check("wa_done", a_wr_done, 1);
    check("wa_sel", a_mem_sel, 0);
    check("wa_addr0", a_mem_addr_0, addr);
    check("wa_data", a_mem_data, data);
  endtask

  task automatic do_read_a(input logic [5:0] addr, input logic [7:0] exp);
    int lat;
    lat = 0;
    @(negedge clk);
    a_rd_req = 1'b1; a_rd_addr = addr;
    #1;
    check("ra_gnt", a_rd_gnt, 1);
    @(negedge clk);
    a_rd_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (a_rd_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("ra_latency", lat, 2);
    check("ra_data", a_rd_data, exp);
  endtask

  task automatic wait_valid_b(input string tag, input int exp_lat, input logic [7:0] exp);
    int lat;
    lat = 0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      #1;
      if (b_rd_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, b_rd_data, exp);
  endtask

  initial begin
    logic [6:0] exp_wg;
    logic [6:0] exp_rg;
    logic [6:0] exp_wd;
    exp_wg = 7'b0010001;
    exp_rg = 7'b1000100;
    exp_wd = 7'b0100010;

    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 8'h77;
      mem_b[i] = 8'(i) ^ 8'h3C;
    end
    rst = 1'b1;
    a_wr_req = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_req = 1'b0; a_rd_addr = '0;
    b_wr_req = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_req = 1'b0; b_rd_addr = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_sel", a_mem_sel, 1);
    check("rst_wr_gnt", a_wr_gnt, 0);
    check("rst_rd_gnt", a_rd_gnt, 0);
    check("rst_wr_done", a_wr_done, 0);
    check("rst_rd_valid", a_rd_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_addr0", a_mem_addr_0, 0);
    check("rst_addr1", a_mem_addr_1, 0);
    check("rst_data", a_mem_data, 0);
    check("rst_rd_data", a_rd_data, 0);
    check("rst_state", a_dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single write 2A <- 5C
    @(negedge clk);
    a_wr_req = 1'b1; a_wr_addr = 6'h2A; a_wr_data = 8'h5C;
    #1;
    check("t2_wr_gnt", a_wr_gnt, 1);
    check("t2_busy_idle", a_busy, 0);
    @(negedge clk);
    a_wr_req = 1'b0;
    #1;
    check("t2_sel", a_mem_sel, 0);
    check("t2_wr_done", a_wr_done, 1);
    check("t2_addr0", a_mem_addr_0, 6'h2A);
    check("t2_data", a_mem_data, 8'h5C);
    check("t2_busy", a_busy, 1);
    check("t2_no_gnt", a_wr_gnt, 0);

    // Read-back of 2A with RD_LAT=1
    @(negedge clk);
    a_rd_req = 1'b1; a_rd_addr = 6'h2A;
    #1;
    check("t3_done_clear", a_wr_done, 0);
    check("t3_sel_idle", a_mem_sel, 1);
    check("t3_rd_gnt", a_rd_gnt, 1);
    @(negedge clk);
    a_rd_req = 1'b0;
    #1;
    check("t3_addr1", a_mem_addr_1, 6'h2A);
    check("t3_busy", a_busy, 1);
    check("t3_early_valid", a_rd_valid, 0);
    @(negedge clk);
    #1;
    check("t3_valid", a_rd_valid, 1);
    check("t3_rd_data", a_rd_data, 8'h5C);
    check("t3_busy_done", a_busy, 0);
    @(negedge clk);
    #1;
    check("t3_valid_pulse", a_rd_valid, 0);
    check("t3_rd_data_hold", a_rd_data, 8'h5C);

    // Contention with FAIR=1: W,R,W,R
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a_wr_req = 1'b1; a_wr_addr = 6'h01; a_wr_data = 8'h11;
        a_rd_req = 1'b1; a_rd_addr = 6'h2A;
      end
      #1;
      check("t4a_wr_gnt", a_wr_gnt, exp_wg[i]);
      check("t4a_rd_gnt", a_rd_gnt, exp_rg[i]);
      check("t4a_wr_done", a_wr_done, exp_wd[i]);
      if (i == 4) begin
        check("t4a_valid_with_gnt", a_rd_valid, 1);
        check("t4a_rd_data", a_rd_data, 8'h5C);
      end
    end
    @(negedge clk);
    a_wr_req = 1'b0; a_rd_req = 1'b0;
    #1;
    check("t4a_busy", a_busy, 1);
    @(negedge clk);
    #1;
    check("t4a_last_valid", a_rd_valid, 1);
    check("t4a_last_data", a_rd_data, 8'h5C);

    // Boundary addresses and data
    do_write_a(6'h00, 8'hFF);
    do_write_a(6'h3F, 8'h00);
    do_read_a(6'h3F, 8'h00);
    do_read_a(6'h00, 8'hFF);
    do_read_a(6'h01, 8'h11);

    // RD_LAT=3 on instance b: addr 05 holds 05^3C = 39
    @(negedge clk);
    b_rd_req = 1'b1; b_rd_addr = 6'h05;
    #1;
    check("t5_rd_gnt", b_rd_gnt, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) b_rd_req = 1'b0;
      #1;
      check("t5_busy", b_busy, 1);
      check("t5_no_valid", b_rd_valid, 0);
    end
    @(negedge clk);
    #1;
    check("t5_valid", b_rd_valid, 1);
    check("t5_rd_data", b_rd_data, 8'h39);
    check("t5_busy_done", b_busy, 0);

    // Contention with FAIR=0: write wins until wr_req drops
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        b_wr_req = 1'b1; b_wr_addr = 6'h10; b_wr_data = 8'hAA;
        b_rd_req = 1'b1; b_rd_addr = 6'h05;
      end
      if (i == 5) b_wr_req = 1'b0;
      #1;
      check("t4b_wr_gnt", b_wr_gnt, (i % 2 == 0) ? 1 : 0);
      check("t4b_rd_gnt", b_rd_gnt, 0);
    end
    @(negedge clk);
    #1;
    check("t4b_rd_gnt_after", b_rd_gnt, 1);
    check("t4b_wr_gnt_after", b_wr_gnt, 0);
    @(negedge clk);
    b_rd_req = 1'b0;
    #1;
    check("t4b_busy", b_busy, 1);
    wait_valid_b("t4b_read", 4, 8'h39);

    @(negedge clk);
    b_rd_req = 1'b1; b_rd_addr = 6'h10;
    #1;
    check("t4b_rb_gnt", b_rd_gnt, 1);
    @(negedge clk);
    b_rd_req = 1'b0;
    wait_valid_b("t4b_readback", 4, 8'hAA);

    // Reset in the middle of a READ on b
    @(negedge clk);
    b_rd_req = 1'b1; b_rd_addr = 6'h05;
    #1;
    check("t1_rd_gnt", b_rd_gnt, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_busy_in_rst", b_busy, 0);
    check("t1_sel_in_rst", b_mem_sel, 1);
    check("t1_gnt_in_rst", b_rd_gnt, 0);
    @(negedge clk);
    #1;
    check("t1_b_addr0", b_mem_addr_0, 0);
    check("t1_b_addr1", b_mem_addr_1, 0);
    check("t1_b_data", b_mem_data, 0);
    check("t1_b_rd_data", b_rd_data, 0);
    check("t1_b_valid", b_rd_valid, 0);
    check("t1_b_state", b_dbg_state, 0);
    check("t1_a_rd_data", a_rd_data, 0);
    check("t1_a_addr0", a_mem_addr_0, 0);
    check("t1_gnt_held_req", b_rd_gnt, 0);
    @(negedge clk);
    rst = 1'b0;
    b_rd_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("t1_no_valid_after", b_rd_valid, 0);
      check("t1_idle_after", b_busy, 0);
      check("t1_sel_after", b_mem_sel, 1);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
